// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus stores to TXDATA are queued in a
// small FIFO and shifted out LSB first; STATUS exposes FIFO and line state.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0020,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overflow_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;

  logic sel_data, sel_stat, push, pop, accept;
  logic full, empty, baud_last, going_idle;
  logic [31:0] status;
  logic unused_wdata;

  assign sel_data  = (DataAdr == BASE_ADDR);
  assign sel_stat  = (DataAdr == BASE_ADDR + 32'd4);
  assign push      = MemWrite && sel_data;
  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign baud_last = (baud_reg == BW'(CLKS_PER_BIT - 1));

  // The FSM pops only from IDLE or at the end of a stop bit; it looks at the
  // registered count, so a same-cycle push is never bypassed to the line.
  assign pop        = !empty && ((state_reg == IDLE) || ((state_reg == STOP) && baud_last));
  assign going_idle = empty && ((state_reg == IDLE) || ((state_reg == STOP) && baud_last));
  assign accept     = push && (!full || pop);
  assign count_next = count_reg + CW'(accept) - CW'(pop);

  assign status   = {20'd0, 4'(count_reg), 4'd0, overflow_reg, (state_reg != IDLE), empty, full};
  assign ReadData = (sel_data || sel_stat) ? status : 32'd0;

  assign unused_wdata = ^WriteData[31:8];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      if (push && !accept) begin
        overflow_reg <= 1'b1;
      end else if (MemWrite && sel_stat) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      tx          <= 1'b1;
      busy        <= 1'b0;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      // busy tracks the state after this edge: still framing or still queued.
      busy <= !going_idle || (count_next != '0);
      unique case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg <= START;
            shift_reg <= mem[rd_ptr_reg];
            baud_reg  <= '0;
            tx        <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_reg    <= '0;
            state_reg   <= DATA;
            tx          <= shift_reg[0];
            bit_idx_reg <= '0;
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
              tx        <= 1'b1;
            end else begin
              shift_reg   <= shift_reg >> 1;
              tx          <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_reg <= '0;
            if (pop) begin
              state_reg <= START;
              shift_reg <= mem[rd_ptr_reg];
              tx        <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          tx        <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus stimulus tasks plus a bit-centre line receiver
// that decodes frames into a queue for comparison against expected bytes.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h0200_0020;
  localparam logic [31:0] STAT  = 32'h0200_0024;
  localparam int          C     = 16;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx;
  logic        busy;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  logic [7:0] exp_q[$];

  int         cyc = 0;
  logic       mon_en = 1'b0;
  logic       mon_active = 1'b0;
  int         mon_pos = 0;
  int         mon_k = 0;
  int         mon_start = 0;
  logic [7:0] mon_byte = 8'h00;

  // Line receiver: samples every bit at its centre after a falling start edge.
  initial begin : line_monitor
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (!mon_en) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_pos    = 0;
          mon_start  = cyc;
        end
      end else begin
        mon_pos++;
        if (mon_pos % C == C / 2) begin
          mon_k = mon_pos / C;
          if (mon_k >= 1 && mon_k <= 8) begin
            mon_byte[mon_k-1] = tx;
          end else if (mon_k == 9) begin
            n_tests++;
            if (tx !== 1'b1) begin
              n_fail++;
              $display("FAIL stop_bit got=%b want=1", tx);
            end
            rx_q.push_back(mon_byte);
            rx_start_q.push_back(mon_start);
            $display("[TB] rx byte %02h start cycle %0d", mon_byte, mon_start);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    DataAdr  = STAT;
    $display("[TB] write addr=%08h data=%08h", a, d);
  endtask

  task automatic wait_idle(input int max_cyc);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < max_cyc) begin
      @(posedge clk); #1;
      i++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle busy=%b after %0d cycles want 0", busy, i);
    end
  endtask

  task automatic compare_rx(input string name);
    n_tests++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s frame_count got=%0d want=%0d", name, rx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++;
        if (rx_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s byte[%0d] got=%02h want=%02h", name, i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    int bad;
    bad = 0;
    reset = 1'b1; MemWrite = 1'b0; DataAdr = STAT; WriteData = 32'd0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_tx low_cycles got=%0d want=0", bad); end
    reset = 1'b0;
    tick(1);
    n_tests++;
    if (ReadData !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_status got=%08h want=00000002", ReadData); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    DataAdr = BASE; #1;
    n_tests++;
    if (ReadData !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_txdata_read got=%08h want=00000002", ReadData); end
    DataAdr = STAT;
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    logic [7:0] b;
    logic       want;
    b = 8'h55;
    rx_q.delete(); rx_start_q.delete();
    bus_write(BASE, {24'hABCDEF, b});
    n_tests++;
    if (ReadData !== 32'h0000_0100 || busy !== 1'b1 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after_store status=%08h busy=%b tx=%b want 00000100/1/1", ReadData, busy, tx);
    end
    tick(1);
    n_tests++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL single_start_edge tx=%b want=0", tx); end
    for (int k = 0; k < 10; k++) begin
      tick((k == 0) ? C / 2 : C);
      want = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      n_tests++;
      if (tx !== want) begin n_fail++; $display("FAIL single_bit%0d got=%b want=%b", k, tx, want); end
    end
    tick(C / 2 - 1);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_before_end got=%b want=1", busy); end
    tick(1);
    n_tests++;
    if (busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL single_busy_end busy=%b tx=%b want 0/1", busy, tx); end
    exp_q.delete(); exp_q.push_back(b);
    compare_rx("single");
  endtask

  task automatic test_back_to_back;
    rx_q.delete(); rx_start_q.delete(); exp_q.delete();
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    foreach (exp_q[i]) bus_write(BASE, {24'h0, exp_q[i]});
    n_tests++;
    if (ReadData !== 32'h0000_0204) begin n_fail++; $display("FAIL b2b_count2 got=%08h want=00000204", ReadData); end
    tick(10 * C - 1);
    n_tests++;
    if (ReadData !== 32'h0000_0104 || tx !== 1'b0) begin n_fail++; $display("FAIL b2b_count1 status=%08h tx=%b want 00000104/0", ReadData, tx); end
    tick(10 * C);
    n_tests++;
    if (ReadData !== 32'h0000_0006 || tx !== 1'b0) begin n_fail++; $display("FAIL b2b_count0 status=%08h tx=%b want 00000006/0", ReadData, tx); end
    tick(10 * C);
    n_tests++;
    if (busy !== 1'b0 || ReadData !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_done busy=%b status=%08h want 0/00000002", busy, ReadData); end
    compare_rx("b2b");
    if (rx_start_q.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        n_tests++;
        if (rx_start_q[i] - rx_start_q[i-1] != 10 * C) begin
          n_fail++;
          $display("FAIL b2b_gap%0d got=%0d want=%0d", i, rx_start_q[i] - rx_start_q[i-1], 10 * C);
        end
      end
    end
  endtask

  task automatic test_random;
    int n;
    logic [7:0] b;
    for (int r = 0; r < 4; r++) begin
      rx_q.delete(); rx_start_q.delete(); exp_q.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(BASE, {24'($urandom), b});
        tick($urandom_range(0, 3));
      end
      wait_idle(12 * C * (DEPTH + 1));
      compare_rx("random");
    end
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    rx_q.delete(); rx_start_q.delete(); exp_q.delete();
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_write(BASE, {24'h0, b});
    tick(2);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) exp_q.push_back(b);
      bus_write(BASE, {24'h0, b});
    end
    n_tests++;
    if (ReadData !== 32'h0000_080D) begin n_fail++; $display("FAIL ovf_status got=%08h want=0000080d", ReadData); end
    bus_write(STAT, 32'hFFFF_FFFF);
    n_tests++;
    if (ReadData !== 32'h0000_0805) begin n_fail++; $display("FAIL ovf_clear got=%08h want=00000805", ReadData); end
    wait_idle(12 * C * (DEPTH + 2));
    compare_rx("overflow");
  endtask

  task automatic test_full_pop_push;
    logic [7:0] b;
    rx_q.delete(); rx_start_q.delete(); exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_write(BASE, {24'h0, b});
    end
    n_tests++;
    if (ReadData !== 32'h0000_0805) begin n_fail++; $display("FAIL fullpop_full got=%08h want=00000805", ReadData); end
    // Line up the store with the edge that starts the second frame.
    tick(10 * C - 8);
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_write(BASE, {24'h0, b});
    n_tests++;
    if (ReadData !== 32'h0000_0805 || tx !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_accept status=%08h tx=%b want 00000805/0", ReadData, tx);
    end
    wait_idle(12 * C * (DEPTH + 2));
    compare_rx("fullpop");
  endtask

  task automatic test_reset_mid;
    int bad;
    rx_q.delete(); rx_start_q.delete();
    for (int i = 0; i < 3; i++) bus_write(BASE, {24'h0, 8'($urandom)});
    n_tests++;
    if (ReadData[11:8] !== 4'd2) begin n_fail++; $display("FAIL rstmid_queued got=%0d want=2", ReadData[11:8]); end
    tick(4 * C + 4);
    reset = 1'b1; mon_en = 1'b0;
    tick(1);
    n_tests++;
    if (tx !== 1'b1 || ReadData !== 32'h0000_0002 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state tx=%b status=%08h busy=%b want 1/00000002/0", tx, ReadData, busy);
    end
    reset = 1'b0; mon_en = 1'b1;
    bad = 0;
    repeat (30 * C) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0 || rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet low_cycles=%0d frames=%0d want 0/0", bad, rx_q.size());
    end
    bus_write(BASE + 32'd8, 32'h0000_00AA);
    bus_write(32'h0200_000C, 32'h0000_00BB);
    bus_write(BASE + 32'd1, 32'h0000_00CC);
    tick(2);
    n_tests++;
    if (ReadData !== 32'h0000_0002 || busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL ignored_writes status=%08h busy=%b tx=%b want 00000002/0/1", ReadData, busy, tx);
    end
    DataAdr = BASE + 32'd8; #1;
    n_tests++;
    if (ReadData !== 32'd0) begin n_fail++; $display("FAIL read_base8 got=%08h want=00000000", ReadData); end
    DataAdr = 32'h0200_000C; #1;
    n_tests++;
    if (ReadData !== 32'd0) begin n_fail++; $display("FAIL read_000c got=%08h want=00000000", ReadData); end
    DataAdr = STAT;
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_overflow();
    test_full_pop_push();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
